// File: rtl/phase_seq_pkg.sv
// Shared types and helpers for the phase_seq timing sequencer.
// Holds the FSM state enum, the idle phase code and the nonzero-phase search.
package phase_seq_pkg;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } state_t;

   localparam int PHASE_IDLE = 0;

   // Upper bound on phases the search helper can scan.
   localparam int MAX_PHASES = 32;
   localparam int IDX_W      = 5;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } nz_res_t;

   // Lowest phase index >= from_idx (and < num) whose duration is nonzero.
   // nz carries one "duration is nonzero" bit per phase.
   function automatic nz_res_t next_nonzero(
      input logic [MAX_PHASES-1:0] nz,
      input int                    num,
      input int                    from_idx
   );
      nz_res_t r;
      r.found = 1'b0;
      r.idx   = '0;
      for (int i = MAX_PHASES - 1; i >= 0; i--) begin
         if (i >= from_idx && i < num && nz[i]) begin
            r.found = 1'b1;
            r.idx   = IDX_W'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/phase_seq_timer.sv
// Down-counter timing the remaining cycles of the current phase.
// Load has priority over enable; expire is high when the count is zero.
module phase_timer
   import phase_seq_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             load_i,
   input  logic [CNT_W-1:0] val_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             expire_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: reload on phase entry, otherwise count down when enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = val_i;
      end else if (en_i && cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o    = cnt_q;
   assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/phase_seq.sv
// Multi-phase timing sequencer: one-shot/loop runs, abort and pass counting.
// Optional PHASE_SEQ_PAUSE_EN adds a pause input that freezes a running sequence.
module phase_seq
   import phase_seq_pkg::*;
#(
   parameter int NUM_PHASES = 3,
   parameter int CNT_W      = 4,
   parameter int PHASE_W    = 2
) (
   input  logic                        clk,
   input  logic                        rstb,
   input  logic                        start,
   input  logic                        stop,
`ifdef PHASE_SEQ_PAUSE_EN
   input  logic                        pause,
`endif
   input  logic                        mode_loop,
   input  logic [NUM_PHASES*CNT_W-1:0] dur_i,
   output logic [PHASE_W-1:0]          phase_o,
   output logic                        busy,
   output logic                        done,
   output logic                        wrap,
   output logic [CNT_W-1:0]            pass_cnt
);

   state_t                      state_q;
   logic [IDX_W-1:0]            idx_q;
   logic [NUM_PHASES*CNT_W-1:0] dur_q;
   logic                        loop_q;
   logic [PHASE_W-1:0]          phase_q;
   logic                        busy_q;
   logic                        done_q;
   logic                        wrap_q;
   logic [CNT_W-1:0]            pass_q;

   logic                        pause_w;
   logic [MAX_PHASES-1:0]       nz_in;
   logic [MAX_PHASES-1:0]       nz_q;
   nz_res_t                     first_in;
   nz_res_t                     first_q;
   nz_res_t                     nxt;

   logic                        run_ok;
   logic                        go;
   logic                        adv;
   logic [IDX_W-1:0]            tgt_idx;
   logic [CNT_W-1:0]            tgt_dur;
   logic [PHASE_W-1:0]          tgt_code;

   logic                        tmr_load;
   logic [CNT_W-1:0]            tmr_val;
   logic                        tmr_en;
   logic [CNT_W-1:0]            tmr_cnt;
   logic                        tmr_last;

`ifdef PHASE_SEQ_PAUSE_EN
   assign pause_w = pause;
`else
   assign pause_w = 1'b0;
`endif

   // Per-phase nonzero flags for incoming and latched durations.
   always_comb begin
      nz_in = '0;
      nz_q  = '0;
      for (int k = 0; k < NUM_PHASES; k++) begin
         nz_in[k] = |dur_i[k*CNT_W +: CNT_W];
         nz_q[k]  = |dur_q[k*CNT_W +: CNT_W];
      end
   end

   assign first_in = next_nonzero(nz_in, NUM_PHASES, 0);
   assign first_q  = next_nonzero(nz_q, NUM_PHASES, 0);
   assign nxt      = next_nonzero(nz_q, NUM_PHASES, int'(idx_q) + 1);

   // Choose the phase entered next and its length.
   always_comb begin
      run_ok = (state_q == ST_RUN) && !stop && !pause_w;
      go     = (state_q == ST_IDLE) && start && !stop
               && first_in.found;
      adv    = run_ok && tmr_last && (nxt.found || loop_q);
      if (go) begin
         tgt_idx = first_in.idx;
      end else if (nxt.found) begin
         tgt_idx = nxt.idx;
      end else begin
         tgt_idx = first_q.idx;
      end
      tgt_dur = '0;
      for (int k = 0; k < NUM_PHASES; k++) begin
         if (tgt_idx == IDX_W'(k)) begin
            tgt_dur = go ? dur_i[k*CNT_W +: CNT_W]
                         : dur_q[k*CNT_W +: CNT_W];
         end
      end
      tgt_code = PHASE_W'(tgt_idx + IDX_W'(1));
      tmr_load = go || adv;
      tmr_val  = tgt_dur - CNT_W'(1);
      tmr_en   = run_ok && !tmr_last;
   end

   phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rstb     (rstb),
      .load_i   (tmr_load),
      .val_i    (tmr_val),
      .en_i     (tmr_en),
      .cnt_o    (tmr_cnt),
      .expire_o (tmr_last)
   );

   // Sequencer FSM with registered phase code, status pulses and pass count.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         dur_q   <= '0;
         loop_q  <= 1'b0;
         phase_q <= PHASE_W'(PHASE_IDLE);
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
         pass_q  <= '0;
      end else begin
         done_q <= 1'b0;
         wrap_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start && !stop) begin
                  dur_q  <= dur_i;
                  loop_q <= mode_loop;
                  if (first_in.found) begin
                     state_q <= ST_RUN;
                     busy_q  <= 1'b1;
                     idx_q   <= tgt_idx;
                     phase_q <= tgt_code;
                     pass_q  <= '0;
                  end else begin
                     done_q <= 1'b1;
                     pass_q <= CNT_W'(1);
                  end
               end
            end
            ST_RUN: begin
               if (stop) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  phase_q <= PHASE_W'(PHASE_IDLE);
               end else if (!pause_w && tmr_last) begin
                  if (nxt.found) begin
                     idx_q   <= tgt_idx;
                     phase_q <= tgt_code;
                  end else begin
                     pass_q <= pass_q + CNT_W'(1);
                     if (loop_q) begin
                        idx_q   <= tgt_idx;
                        phase_q <= tgt_code;
                        wrap_q  <= 1'b1;
                     end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        phase_q <= PHASE_W'(PHASE_IDLE);
                        done_q  <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign phase_o  = phase_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign wrap     = wrap_q;
   assign pass_cnt = pass_q;

endmodule

// File: tb/tb_phase_seq.sv
// Directed bench for phase_seq (NUM_PHASES=3, CNT_W=4).
// Covers one-shot, loop, zero phases, abort, reset and optional pause.
module tb_phase_seq;

   logic        clk;
   logic        rstb;
   logic        start;
   logic        stop;
   logic        pause;
   logic        mode_loop;
   logic [11:0] dur_i;
   logic [1:0]  phase_o;
   logic        busy;
   logic        done;
   logic        wrap;
   logic [3:0]  pass_cnt;

   int checks;
   int errors;

   phase_seq #(
      .NUM_PHASES (3),
      .CNT_W      (4),
      .PHASE_W    (2)
   ) dut (
      .clk       (clk),
      .rstb      (rstb),
      .start     (start),
      .stop      (stop),
`ifdef PHASE_SEQ_PAUSE_EN
      .pause     (pause),
`endif
      .mode_loop (mode_loop),
      .dur_i     (dur_i),
      .phase_o   (phase_o),
      .busy      (busy),
      .done      (done),
      .wrap      (wrap),
      .pass_cnt  (pass_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int e1 [10] = '{1, 1, 1, 1, 2, 2, 2, 3, 0, 0};
   int pat [8] = '{1, 1, 1, 1, 2, 2, 2, 3};
   int e3 [7]  = '{1, 1, 3, 3, 3, 0, 0};

   initial begin
      checks    = 0;
      errors    = 0;
      rstb      = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      pause     = 1'b0;
      mode_loop = 1'b0;
      dur_i     = '0;
      step();
      step();
      chk("rst_phase", 32'(phase_o), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_wrap", 32'(wrap), 0);
      chk("rst_pass", 32'(pass_cnt), 0);
      rstb = 1'b1;
      step();

      // 1: one-shot {4,3,1}; start and dur_i change mid-run are ignored
      dur_i = 12'h134;
      mode_loop = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         chk("t1_phase", 32'(phase_o), 32'(e1[k-1]));
         chk("t1_done", 32'(done), (k == 9) ? 1 : 0);
         chk("t1_busy", 32'(busy), (k <= 8) ? 1 : 0);
         if (k == 9) chk("t1_pass", 32'(pass_cnt), 1);
         if (k == 2) begin
            start = 1'b1;
            dur_i = 12'hFFF;
         end
         if (k == 3) begin
            start = 1'b0;
            dur_i = 12'h134;
         end
         step();
      end

      // 2: loop {4,3,1} for 20 cycles, then stop
      dur_i = 12'h134;
      mode_loop = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         chk("t2_phase", 32'(phase_o), 32'(pat[(k-1)%8]));
         chk("t2_wrap", 32'(wrap), (k == 9 || k == 17) ? 1 : 0);
         chk("t2_done", 32'(done), 0);
         if (k == 20) chk("t2_pass", 32'(pass_cnt), 2);
         step();
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("t2_stop_phase", 32'(phase_o), 0);
      chk("t2_stop_pass", 32'(pass_cnt), 2);
      chk("t2_stop_done", 32'(done), 0);
      step();

      // 3: one-shot {2,0,3}; code 2 never shows
      dur_i = 12'h302;
      mode_loop = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         chk("t3_phase", 32'(phase_o), 32'(e3[k-1]));
         chk("t3_done", 32'(done), (k == 6) ? 1 : 0);
         step();
      end

      // 4: all durations zero
      dur_i = 12'h000;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t4_busy", 32'(busy), 0);
      chk("t4_done", 32'(done), 1);
      chk("t4_pass", 32'(pass_cnt), 1);
      chk("t4_phase", 32'(phase_o), 0);
      step();
      chk("t4_done_clr", 32'(done), 0);

      // 5: loop, stop on 3rd cycle of phase 1; then start&stop in IDLE
      dur_i = 12'h134;
      mode_loop = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         chk("t5_phase", 32'(phase_o), 1);
         if (k == 3) stop = 1'b1;
         step();
      end
      stop = 1'b0;
      chk("t5_stop_phase", 32'(phase_o), 0);
      chk("t5_stop_busy", 32'(busy), 0);
      chk("t5_stop_done", 32'(done), 0);
      chk("t5_stop_wrap", 32'(wrap), 0);
      chk("t5_stop_pass", 32'(pass_cnt), 0);
      start = 1'b1;
      stop = 1'b1;
      step();
      start = 1'b0;
      stop = 1'b0;
      chk("t5_both_busy", 32'(busy), 0);
      chk("t5_both_phase", 32'(phase_o), 0);
      chk("t5_both_done", 32'(done), 0);
      step();
      chk("t5_both_idle", 32'(phase_o), 0);

      // 6: reset mid phase 2
      mode_loop = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         if (k == 5) chk("t6_phase2", 32'(phase_o), 2);
         if (k == 6) rstb = 1'b0;
         step();
      end
      rstb = 1'b1;
      chk("t6_rst_phase", 32'(phase_o), 0);
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_done", 32'(done), 0);
      chk("t6_rst_wrap", 32'(wrap), 0);
      chk("t6_rst_pass", 32'(pass_cnt), 0);
      step();
      chk("t6_after_busy", 32'(busy), 0);
      chk("t6_after_done", 32'(done), 0);

`ifdef PHASE_SEQ_PAUSE_EN
      // 6b: pause 5 cycles inside phase 1 -> phase 1 spans 9 cycles
      dur_i = 12'h134;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         chk("t6p_phase", 32'(phase_o), (k <= 9) ? 1 : 2);
         pause = (k >= 2 && k <= 6) ? 1'b1 : 1'b0;
         step();
      end
      pause = 1'b0;
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("t6p_stop", 32'(phase_o), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
